// File: rtl/switch_debounce_pkg.sv
// Shared constants, types and bus pack/unpack helpers for the DIP-switch debouncer.
// The optional sticky change flag is controlled by SWITCH_DEBOUNCE_STICKY_EN.
package switch_debounce_pkg;

    localparam int NUM_GROUPS = 8;
    localparam int GROUP_W    = 8;
    localparam int BUS_W      = NUM_GROUPS * GROUP_W;

    // Pins idle high; the MMIO driver performs the inversion.
    localparam logic [GROUP_W-1:0] IDLE_LEVEL = 8'hFF;

    typedef logic [GROUP_W-1:0]           group_t;
    typedef group_t [NUM_GROUPS-1:0]      group_arr_t;

    // Per-clock decision for one group, in priority order.
    typedef enum logic [1:0] {
        ACT_ABORT   = 2'd0,
        ACT_RESTART = 2'd1,
        ACT_COMMIT  = 2'd2,
        ACT_COUNT   = 2'd3
    } dbnc_action_t;

    // Group g occupies bus bits [g*GROUP_W +: GROUP_W].
    function automatic group_arr_t unpack_groups(input logic [BUS_W-1:0] bus);
        group_arr_t groups;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            groups[g] = bus[g*GROUP_W +: GROUP_W];
        end
        return groups;
    endfunction

    function automatic logic [BUS_W-1:0] pack_groups(input group_arr_t groups);
        logic [BUS_W-1:0] bus;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            bus[g*GROUP_W +: GROUP_W] = groups[g];
        end
        return bus;
    endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Pin-side bundle of the DIP-switch debouncer. change_flag/change_clr exist only
// when SWITCH_DEBOUNCE_STICKY_EN is defined.
interface switch_debouncer_if;
    import switch_debounce_pkg::*;

    // No handshake: raw groups are free-running asynchronous inputs, changed is a
    // one-cycle pulse with no back-pressure, change_clr is a level sampled each clock.
    group_t                  dip_raw0, dip_raw1, dip_raw2, dip_raw3;
    group_t                  dip_raw4, dip_raw5, dip_raw6, dip_raw7;
    group_t                  dip_clean0, dip_clean1, dip_clean2, dip_clean3;
    group_t                  dip_clean4, dip_clean5, dip_clean6, dip_clean7;
    logic [NUM_GROUPS-1:0]   changed;
`ifdef SWITCH_DEBOUNCE_STICKY_EN
    logic                    change_flag;
    logic                    change_clr;

    modport master (
        output dip_raw0, dip_raw1, dip_raw2, dip_raw3,
               dip_raw4, dip_raw5, dip_raw6, dip_raw7, change_clr,
        input  dip_clean0, dip_clean1, dip_clean2, dip_clean3,
               dip_clean4, dip_clean5, dip_clean6, dip_clean7, changed, change_flag
    );
    modport slave (
        input  dip_raw0, dip_raw1, dip_raw2, dip_raw3,
               dip_raw4, dip_raw5, dip_raw6, dip_raw7, change_clr,
        output dip_clean0, dip_clean1, dip_clean2, dip_clean3,
               dip_clean4, dip_clean5, dip_clean6, dip_clean7, changed, change_flag
    );
`else
    modport master (
        output dip_raw0, dip_raw1, dip_raw2, dip_raw3,
               dip_raw4, dip_raw5, dip_raw6, dip_raw7,
        input  dip_clean0, dip_clean1, dip_clean2, dip_clean3,
               dip_clean4, dip_clean5, dip_clean6, dip_clean7, changed
    );
    modport slave (
        input  dip_raw0, dip_raw1, dip_raw2, dip_raw3,
               dip_raw4, dip_raw5, dip_raw6, dip_raw7,
        output dip_clean0, dip_clean1, dip_clean2, dip_clean3,
               dip_clean4, dip_clean5, dip_clean6, dip_clean7, changed
    );
`endif

endinterface

// File: rtl/switch_debouncer_debounce_group.sv
// One 8-bit DIP group: 2-flop synchroniser followed by a candidate/counter debouncer
// that commits the whole word atomically and pulses changed on commit.
module debounce_group
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic   clk,
    input  logic   reset,
    input  group_t raw,
    output group_t clean,
    output logic   changed
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    group_t           s1, s2, cand, stable;
    logic [CNT_W-1:0] cnt;
    dbnc_action_t     action;

    always_comb begin
        action = ACT_COUNT;
        if (s2 == stable) begin
            action = ACT_ABORT;
        end else if (s2 != cand) begin
            action = ACT_RESTART;
        end else if (cnt == CNT_LAST) begin
            action = ACT_COMMIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= IDLE_LEVEL;
            s2      <= IDLE_LEVEL;
            cand    <= IDLE_LEVEL;
            stable  <= IDLE_LEVEL;
            cnt     <= '0;
            changed <= 1'b0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            changed <= 1'b0;
            unique case (action)
                ACT_ABORT, ACT_RESTART: begin
                    cand <= s2;
                    cnt  <= '0;
                end
                ACT_COMMIT: begin
                    stable  <= cand;
                    cnt     <= '0;
                    changed <= 1'b1;
                end
                ACT_COUNT: cnt <= cnt + 1'b1;
            endcase
        end
    end

    assign clean = stable;

endmodule

// File: rtl/switch_debouncer.sv
// DIP-switch front end: eight independent debounce groups plus, when
// SWITCH_DEBOUNCE_STICKY_EN is defined, a sticky "some group changed" flag.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               reset,
    switch_debouncer_if.slave  sw
);
    import switch_debounce_pkg::*;

    logic [BUS_W-1:0]      raw_bus, clean_bus;
    group_arr_t            raw_g, clean_g;
    logic [NUM_GROUPS-1:0] changed;

    assign raw_bus = {sw.dip_raw7, sw.dip_raw6, sw.dip_raw5, sw.dip_raw4,
                      sw.dip_raw3, sw.dip_raw2, sw.dip_raw1, sw.dip_raw0};
    assign raw_g   = unpack_groups(raw_bus);

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
        debounce_group #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_group (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_g[g]),
            .clean  (clean_g[g]),
            .changed(changed[g])
        );
    end

    assign clean_bus     = pack_groups(clean_g);
    assign sw.dip_clean0 = clean_bus[0*GROUP_W +: GROUP_W];
    assign sw.dip_clean1 = clean_bus[1*GROUP_W +: GROUP_W];
    assign sw.dip_clean2 = clean_bus[2*GROUP_W +: GROUP_W];
    assign sw.dip_clean3 = clean_bus[3*GROUP_W +: GROUP_W];
    assign sw.dip_clean4 = clean_bus[4*GROUP_W +: GROUP_W];
    assign sw.dip_clean5 = clean_bus[5*GROUP_W +: GROUP_W];
    assign sw.dip_clean6 = clean_bus[6*GROUP_W +: GROUP_W];
    assign sw.dip_clean7 = clean_bus[7*GROUP_W +: GROUP_W];
    assign sw.changed    = changed;

`ifdef SWITCH_DEBOUNCE_STICKY_EN
    logic change_flag;

    // A pending pulse beats a concurrent clear so no commit is ever lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            change_flag <= 1'b0;
        end else if (|changed) begin
            change_flag <= 1'b1;
        end else if (sw.change_clr) begin
            change_flag <= 1'b0;
        end
    end

    assign sw.change_flag = change_flag;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (DEBOUNCE_CYCLES = 4): directed scenarios plus random
// pin activity, all checked against a run-length reference model.
module tb_switch_debouncer;
    localparam int D = 4;
    localparam int G = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] raw [G];
    logic       change_clr = 1'b0;

    switch_debouncer_if sw();

    assign sw.dip_raw0 = raw[0];
    assign sw.dip_raw1 = raw[1];
    assign sw.dip_raw2 = raw[2];
    assign sw.dip_raw3 = raw[3];
    assign sw.dip_raw4 = raw[4];
    assign sw.dip_raw5 = raw[5];
    assign sw.dip_raw6 = raw[6];
    assign sw.dip_raw7 = raw[7];
`ifdef SWITCH_DEBOUNCE_STICKY_EN
    assign sw.change_clr = change_clr;
`endif

    switch_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk  (clk),
        .reset(reset),
        .sw   (sw)
    );

    wire [63:0] clean_bus = {sw.dip_clean7, sw.dip_clean6, sw.dip_clean5, sw.dip_clean4,
                             sw.dip_clean3, sw.dip_clean2, sw.dip_clean1, sw.dip_clean0};

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A group adopts value v once v has been seen at the synchroniser output on
    // D+1 consecutive edges while differing from the accepted value.
    logic [7:0] m_p1 [G];
    logic [7:0] m_p2 [G];
    logic [7:0] m_stable [G];
    logic [7:0] m_hist [G][$];
    logic [7:0] m_changed = '0;
    logic       m_flag = 1'b0;
    logic       model_ok = 1'b0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            for (int g = 0; g < G; g++) begin
                m_p1[g] = 8'hFF;
                m_p2[g] = 8'hFF;
                m_stable[g] = 8'hFF;
                m_hist[g].delete();
            end
            m_changed = '0;
            m_flag = 1'b0;
            model_ok = 1'b1;
        end else begin
            if (|m_changed) m_flag = 1'b1;
            else if (change_clr) m_flag = 1'b0;
            m_changed = '0;
            for (int g = 0; g < G; g++) begin
                logic [7:0] v;
                logic       same;
                v = m_p2[g];
                m_hist[g].push_back(v);
                if (m_hist[g].size() > D + 1) void'(m_hist[g].pop_front());
                same = (m_hist[g].size() == D + 1);
                foreach (m_hist[g][k]) if (m_hist[g][k] != v) same = 1'b0;
                if (same && v != m_stable[g]) begin
                    m_stable[g] = v;
                    m_changed[g] = 1'b1;
                end
                m_p2[g] = m_p1[g];
                m_p1[g] = raw[g];
            end
        end
    end

    function automatic logic [63:0] model_bus();
        logic [63:0] b;
        for (int g = 0; g < G; g++) b[g*8 +: 8] = m_stable[g];
        return b;
    endfunction

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            check("model_clean", clean_bus, model_bus());
            check("model_changed", 64'(sw.changed), 64'(m_changed));
`ifdef SWITCH_DEBOUNCE_STICKY_EN
            check("model_flag", 64'(sw.change_flag), 64'(m_flag));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] exp_bus;
        int pulses;

        for (int g = 0; g < G; g++) raw[g] = 8'hFF;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset: idle for 20 clocks
        for (int i = 0; i < 20; i++) begin
            tick();
            check("rst_clean", clean_bus, {64{1'b1}});
            check("rst_changed", 64'(sw.changed), 64'h0);
`ifdef SWITCH_DEBOUNCE_STICKY_EN
            check("rst_flag", 64'(sw.change_flag), 64'h0);
`endif
        end

        // Clean change on group 3
        raw[3] = 8'hFE;
        exp_bus = {64{1'b1}};
        exp_bus[31:24] = 8'hFE;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 7) begin
                check("cc_hold", 64'(sw.dip_clean3), 64'hFF);
                check("cc_quiet", 64'(sw.changed), 64'h0);
            end else begin
                check("cc_commit", clean_bus, exp_bus);
                check("cc_pulse", 64'(sw.changed), 64'h08);
            end
        end
        tick();
        check("cc_pulse_end", 64'(sw.changed), 64'h0);

        // Bounce on group 0: toggles every 2 clocks, then holds
        for (int i = 0; i < 20; i++) begin
            raw[0] = (((i / 2) % 2) == 0) ? 8'h7F : 8'hFF;
            tick();
            check("bnc_quiet", 64'(sw.changed[0]), 64'h0);
            check("bnc_clean", 64'(sw.dip_clean0), 64'hFF);
        end
        raw[0] = 8'h7F;
        pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (sw.changed[0]) pulses++;
            if (e < 7) check("bnc_hold", 64'(sw.dip_clean0), 64'hFF);
            if (e == 7) check("bnc_commit", 64'(sw.dip_clean0), 64'h7F);
        end
        check("bnc_pulses", 64'(pulses), 64'd1);

        // Simultaneous commits on groups 1 and 6
        raw[1] = 8'h00;
        raw[6] = 8'hA5;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 7) check("sim_quiet", 64'(sw.changed), 64'h0);
        end
        check("sim_changed", 64'(sw.changed), 64'h42);
        check("sim_clean1", 64'(sw.dip_clean1), 64'h00);
        check("sim_clean6", 64'(sw.dip_clean6), 64'hA5);
        tick();

        // Reset mid-debounce on group 5
        raw[5] = 8'h0F;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("rmid_pre", 64'(sw.dip_clean5), 64'hFF);
        end
        reset = 1'b1;
        tick();
        check("rmid_in_rst", 64'(sw.dip_clean5), 64'hFF);
        tick();
        check("rmid_in_rst", 64'(sw.dip_clean5), 64'hFF);
        check("rmid_clean0", 64'(sw.dip_clean0), 64'hFF);
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 7) begin
                check("rmid_hold", 64'(sw.dip_clean5), 64'hFF);
                check("rmid_quiet", 64'(sw.changed[5]), 64'h0);
            end
        end
        check("rmid_commit", 64'(sw.dip_clean5), 64'h0F);
        check("rmid_pulse", 64'(sw.changed[5]), 64'h1);
        tick();
        check("rmid_pulse_end", 64'(sw.changed[5]), 64'h0);

`ifdef SWITCH_DEBOUNCE_STICKY_EN
        // Sticky flag: clear concurrent with a commit loses, lone clear wins
        change_clr = 1'b1;
        tick();
        change_clr = 1'b0;
        check("stk_cleared", 64'(sw.change_flag), 64'h0);
        raw[2] = 8'h11;
        tick();
        tick();
        tick();
        raw[4] = 8'h22;
        for (int e = 4; e <= 7; e++) tick();
        check("stk_first_pulse", 64'(sw.changed), 64'h04);
        tick();
        check("stk_set", 64'(sw.change_flag), 64'h1);
        tick();
        tick();
        check("stk_second_pulse", 64'(sw.changed), 64'h10);
        change_clr = 1'b1;
        tick();
        check("stk_set_wins", 64'(sw.change_flag), 64'h1);
        tick();
        check("stk_clr", 64'(sw.change_flag), 64'h0);
        change_clr = 1'b0;
`endif

        // Random pin activity with occasional resets
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int g = 0; g < G; g++) begin
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0: raw[g] = 8'($urandom);
                        1: raw[g] = 8'hFF;
                        2: raw[g] = raw[g] ^ (8'h01 << $urandom_range(0, 7));
                        default: raw[g] = raw[g];
                    endcase
                end
            end
            reset = ($urandom_range(0, 299) == 0);
`ifdef SWITCH_DEBOUNCE_STICKY_EN
            change_clr = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end
        reset = 1'b0;
        change_clr = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
